// File: rtl/fetch_unit.sv
// Instruction-fetch stage.
// Issues sequential word fetches to a 1-cycle-latency synchronous instruction
// memory, buffers returned words with their PCs in a small circular prefetch
// FIFO, and presents the head to decode over a valid/ready handshake.
// A redirect flushes the FIFO and drops whatever response is still in flight.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     reset,          // active-low, asynchronous
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic [31:0]              imem_rdata,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic                     id_valid,
    input  logic                     id_ready,
    output logic [31:0]              id_instr,
    output logic [31:0]              id_pc,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    // Occupancy plus in-flight credit is compared against DEPTH at CW+1 bits
    // so the sum can never wrap.
    localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);
    localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);

    // Fetch-side state
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic          inflight_q, inflight_d;
    logic          kill_q, kill_d;

    // FIFO state
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   entry_instr_q [DEPTH];
    logic [31:0]   entry_pc_q    [DEPTH];
    logic [DEPTH-1:0] entry_wr_en;

    // Control strobes
    logic          issue;
    logic          push;
    logic          pop;
    logic [CW:0]   credit_used;

    // The low two bits of the redirect target are discarded by design.
    logic          unused_redirect_lo;
    assign unused_redirect_lo = ^redirect_pc[1:0];

    // Credit check: buffered entries plus the outstanding request must leave
    // room for one more response. A same-cycle pop deliberately does not count.
    always_comb begin
        credit_used = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
        issue       = reset & ~redirect_valid & (credit_used < DEPTH_C);
    end

    // Response push and decode pop; a redirect suppresses both.
    always_comb begin
        push = inflight_q & ~kill_q & ~redirect_valid;
        pop  = id_valid & id_ready;
    end

    // Next-state for the fetch PC, the captured request PC, and the kill flag.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = issue;
        kill_d     = 1'b0;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            // Anything outstanding right now belongs to the old stream.
            kill_d     = inflight_q;
        end else if (issue) begin
            fetch_pc_d = fetch_pc_q + 32'd4;   // wraps naturally at 2^32
            req_pc_d   = fetch_pc_q;
        end
    end

    // Next-state for FIFO pointers and occupancy; a redirect flushes everything.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect_valid) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            inflight_q <= 1'b0;
            kill_q     <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            kill_q     <= kill_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Per-entry write enables decoded from the write pointer.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign entry_wr_en[gi] = push && (wr_ptr_q == PW'(gi));
        end
    endgenerate

    // FIFO storage; contents need no reset because the outputs are gated by
    // occupancy.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_wr_en[i]) begin
                entry_instr_q[i] <= imem_rdata;
                entry_pc_q[i]    <= req_pc_q;
            end
        end
    end

    // Output decode: memory interface and decode-side head presentation.
    always_comb begin
        imem_req   = issue;
        imem_addr  = fetch_pc_q;
        fifo_count = count_q;
        id_valid   = (count_q != '0) & ~redirect_valid;
        id_instr   = 32'd0;
        id_pc      = 32'd0;
        if (id_valid) begin
            id_instr = entry_instr_q[rd_ptr_q];
            id_pc    = entry_pc_q[rd_ptr_q];
        end
    end

    // The credit rule guarantees a response always has a free slot.
    no_push_when_full: assert property (@(posedge clk) disable iff (!reset)
        !(push && (count_q == FULL_C)));

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of decode/execute.
- Generates sequential PCs and drives the synchronous instruction memory, which has 1-cycle read latency.
- Buffers returned words and their PCs in a small prefetch FIFO and hands them to decode over a valid/ready handshake.
- Accepts a redirect (branch/jump target) that flushes all buffered and in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- DEPTH, 4, prefetch FIFO entries; power of 2, minimum 2.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = in reset)
- imem_req  output  1  read strobe to instruction memory; data is returned the next cycle
- imem_addr  output  32  byte address of the read; bits [1:0] always 0
- imem_rdata  input  32  instruction word, valid in the cycle after imem_req=1
- redirect_valid  input  1  one-cycle pulse: discard the current stream and restart at redirect_pc
- redirect_pc  input  32  new fetch address; bits [1:0] are ignored and forced to 0
- id_valid  output  1  FIFO head holds a valid instruction
- id_ready  input  1  decode accepts the head this cycle
- id_instr  output  32  head instruction word; 0 when id_valid=0
- id_pc  output  32  PC of the head instruction; 0 when id_valid=0
- fifo_count  output  log2(DEPTH)+1  number of occupied entries

Behaviour:
Reset values (reset=0, asynchronous):
- fetch_pc=RESET_PC, FIFO empty, inflight=0, kill=0.
- Outputs: imem_req=0, imem_addr=RESET_PC, id_valid=0, id_instr=0, id_pc=0, fifo_count=0.

Request issue:
- imem_addr = fetch_pc, combinational.
- imem_req = reset & ~redirect_valid & (fifo_count + inflight < DEPTH).
- Credit is conservative: a pop in the same cycle does not free a slot for issue that cycle.
- On issue: fetch_pc <= fetch_pc + 4, with 32-bit wrap (32'hFFFF_FFFC -> 0); req_pc_q <= fetch_pc; inflight <= 1. Otherwise inflight <= 0.

Response:
- In the cycle where inflight=1 and kill=0, imem_rdata is pushed into the FIFO together with req_pc_q.
- If kill=1, the response is dropped.
- Pushed entries become visible on id_* in the next cycle; there is no bypass.

Handshake:
- id_valid = (fifo_count != 0) & ~redirect_valid.
- A pop occurs only when id_valid & id_ready.
- Push and pop in the same cycle leave fifo_count unchanged.
- Overflow is impossible by construction of the credit rule. The verifier must assert that no push ever occurs when the FIFO is full.
- id_instr and id_pc are stable while id_valid=1 and id_ready=0.

Redirect (highest priority):
- In the cycle where redirect_valid=1: no pop and no push take effect, and the FIFO is flushed (fifo_count <= 0).
- fetch_pc <= {redirect_pc[31:2], 2'b00}.
- kill <= inflight, so a response still in flight is discarded next cycle. The request issued one cycle before the redirect is the one dropped.
- kill clears the cycle after it is consumed.
- Back-to-back redirects: the last one wins, and each one flushes again.

Latency:
- Reset release: imem_req=1 in cycle 0, data arrives in cycle 1, id_valid=1 in cycle 2.
- Redirect in cycle R: first new imem_req in R+1, id_valid in R+3.
- Steady state with id_ready held at 1: one instruction per cycle, PCs strictly +4.

FIFO:
- Circular buffer with read/write pointers that wrap modulo DEPTH.
- Entries are {instr, pc}.

Reset mid-operation:
- All state clears immediately; any memory response arriving after reset is released is ignored, because inflight was cleared.

Test Plan:
1. Reset release, id_ready=1, memory returns addr*2 -> id_pc = 0, 4, 8, 12 on consecutive cycles starting 2 cycles after release; id_instr = 0, 8, 16, 24.
2. id_ready=0 from release -> exactly 4 requests issued (addr 0..12); fifo_count rises to 4; imem_req stays low; id_pc stays 0 and stable. Raise id_ready -> fetching resumes at addr 16, with no loss or duplicates.
3. Steady stream at PC 0x20, then redirect_valid with redirect_pc=0x103 -> the in-flight word for 0x24 is discarded; id_valid=0 for cycles R..R+2; next delivered id_pc=0x100, then 0x104.
4. Redirect in two consecutive cycles, to 0x40 and then 0x80 -> the first delivered id_pc is 0x80; no 0x40 entry ever appears.
5. reset asserted asynchronously mid-stream with the FIFO holding 3 entries -> all outputs return to reset values without waiting for a clock edge. After release, fetch restarts at RESET_PC and stale memory data is not pushed.
6. RESET_PC=32'hFFFF_FFF8, id_ready=1 -> id_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
